// File: rtl/ps2_mouse_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_mouse_ctrl
// Purpose  : Brings a PS/2 mouse up in streaming mode by sequencing the PS/2
//            transceiver (reset 0xFF, expect FA/AA/00, enable 0xF4, expect FA).
//            It then assembles 3-byte movement packets into signed 9-bit
//            deltas and button states.
// Ports    : clk_i        system clock
//            reset_i      synchronous active-high reset
//            rx_data_i    received byte from transceiver
//            rx_done_i    1-cycle strobe, rx_data_i valid
//            tx_done_i    1-cycle strobe, transmit complete
//            tx_en_o      1-cycle strobe, start transmit of tx_data_o
//            tx_data_o    command byte to send (holds between strobes)
//            init_done_o  high once streaming is enabled
//            error_o      high in the terminal ERROR state
//            pkt_valid_o  1-cycle strobe, new packet on dx_o/dy_o/btn_o
//            dx_o, dy_o   signed deltas (two's complement, 0 on overflow)
//            btn_o        {middle, right, left}
// Options  : MOUSE_RETRY_EN - init failures restart the bring-up sequence up
//            to MAX_RETRIES times before ERROR latches.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_mouse_ctrl #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int PKT_GAP_CYCLES = 2_500_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_done_i,
    input  logic       tx_done_i,
    output logic       tx_en_o,
    output logic [7:0] tx_data_o,
    output logic       init_done_o,
    output logic       error_o,
    output logic       pkt_valid_o,
    output logic [8:0] dx_o,
    output logic [8:0] dy_o,
    output logic [2:0] btn_o
);

    localparam int c_wait_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_gap_w  = $clog2(PKT_GAP_CYCLES + 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(TIMEOUT_CYCLES);
    localparam logic [c_gap_w-1:0]  c_gap_max  = c_gap_w'(PKT_GAP_CYCLES);

    localparam logic [7:0] c_cmd_reset  = 8'hFF;
    localparam logic [7:0] c_cmd_enable = 8'hF4;
    localparam logic [7:0] c_rsp_ack    = 8'hFA;
    localparam logic [7:0] c_rsp_bat    = 8'hAA;
    localparam logic [7:0] c_rsp_id     = 8'h00;

    localparam logic [3:0] c_send_rst     = 4'd0;
    localparam logic [3:0] c_wait_tx_rst  = 4'd1;
    localparam logic [3:0] c_wait_ack_rst = 4'd2;
    localparam logic [3:0] c_wait_bat     = 4'd3;
    localparam logic [3:0] c_wait_id      = 4'd4;
    localparam logic [3:0] c_send_en      = 4'd5;
    localparam logic [3:0] c_wait_tx_en   = 4'd6;
    localparam logic [3:0] c_wait_ack_en  = 4'd7;
    localparam logic [3:0] c_stream_b0    = 4'd8;
    localparam logic [3:0] c_stream_b1    = 4'd9;
    localparam logic [3:0] c_stream_b2    = 4'd10;
    localparam logic [3:0] c_error        = 4'd11;

    logic [3:0]          r_state;
    logic [3:0]          w_next;
    logic [3:0]          w_fail_state;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic                w_in_init_wait;
    logic                w_in_pkt;
    logic                w_wait_expired;
    logic                w_gap_expired;
    logic [7:0]          w_expect;
    logic                w_rx_ok;

    // Header byte keeps only the fields used later: {yovf, xovf, ysign, xsign, btn[2:0]}
    logic [6:0]          r_hdr;
    logic [7:0]          r_b1;

    logic                r_tx_en;
    logic [7:0]          r_tx_data;
    logic                r_init_done;
    logic                r_error;
    logic                r_pkt_valid;
    logic [8:0]          r_dx;
    logic [8:0]          r_dy;
    logic [2:0]          r_btn;

    logic                w_tx_en_nxt;
    logic [7:0]          w_tx_data_nxt;
    logic                w_init_done_nxt;
    logic                w_error_nxt;

    // ------------------------------------------------------------------------
    // Failure destination: either retry the whole bring-up or latch ERROR
    // ------------------------------------------------------------------------
`ifdef MOUSE_RETRY_EN
    localparam int c_retry_w = $clog2(MAX_RETRIES + 2);
    localparam logic [c_retry_w-1:0] c_retry_max = c_retry_w'(MAX_RETRIES);

    logic [c_retry_w-1:0] r_retry;

    always_comb begin
        w_fail_state = (r_retry < c_retry_max) ? c_send_rst : c_error;
    end

    // The only way back into SEND_RST from another state is a failure, so
    // that transition is what counts a retry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_retry <= '0;
        end else if (w_next == c_send_rst && r_state != c_send_rst) begin
            r_retry <= r_retry + 1'b1;
        end else if (w_next == c_stream_b0 && r_state == c_wait_ack_en) begin
            r_retry <= '0;
        end
    end
`else
    always_comb begin
        w_fail_state = c_error;
    end
`endif

    // ------------------------------------------------------------------------
    // Wait / gap timers
    // ------------------------------------------------------------------------
    always_comb begin
        w_in_init_wait = (r_state == c_wait_tx_rst)  || (r_state == c_wait_ack_rst) ||
                         (r_state == c_wait_bat)     || (r_state == c_wait_id)      ||
                         (r_state == c_wait_tx_en)   || (r_state == c_wait_ack_en);
        w_in_pkt       = (r_state == c_stream_b1) || (r_state == c_stream_b2);
        w_wait_expired = w_in_init_wait && (r_wait_cnt == c_wait_max);
        w_gap_expired  = w_in_pkt && (r_gap_cnt == c_gap_max);
    end

    // Counter restarts whenever the state changes, so each wait state gets
    // its own full timeout window.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wait_cnt <= '0;
        end else if (!w_in_init_wait || (w_next != r_state)) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_gap_cnt <= '0;
        end else if (!w_in_pkt || rx_done_i) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Expected response byte for the ack/BAT/ID wait states
    // ------------------------------------------------------------------------
    always_comb begin
        w_expect = c_rsp_ack;
        case (r_state)
            c_wait_bat: w_expect = c_rsp_bat;
            c_wait_id:  w_expect = c_rsp_id;
            default:    w_expect = c_rsp_ack;
        endcase
        w_rx_ok = (rx_data_i == w_expect);
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_send_rst;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic. A received byte takes priority over a timeout
    // that expires in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_send_rst: w_next = c_wait_tx_rst;
            c_wait_tx_rst: begin
                if (tx_done_i)           w_next = c_wait_ack_rst;
                else if (w_wait_expired) w_next = w_fail_state;
            end
            c_wait_ack_rst: begin
                if (rx_done_i)           w_next = w_rx_ok ? c_wait_bat : w_fail_state;
                else if (w_wait_expired) w_next = w_fail_state;
            end
            c_wait_bat: begin
                if (rx_done_i)           w_next = w_rx_ok ? c_wait_id : w_fail_state;
                else if (w_wait_expired) w_next = w_fail_state;
            end
            c_wait_id: begin
                if (rx_done_i)           w_next = w_rx_ok ? c_send_en : w_fail_state;
                else if (w_wait_expired) w_next = w_fail_state;
            end
            c_send_en: w_next = c_wait_tx_en;
            c_wait_tx_en: begin
                if (tx_done_i)           w_next = c_wait_ack_en;
                else if (w_wait_expired) w_next = w_fail_state;
            end
            c_wait_ack_en: begin
                if (rx_done_i)           w_next = w_rx_ok ? c_stream_b0 : w_fail_state;
                else if (w_wait_expired) w_next = w_fail_state;
            end
            // Header bytes always carry bit 3 set; anything else is stray
            // data and is dropped to regain packet alignment.
            c_stream_b0: begin
                if (rx_done_i && rx_data_i[3]) w_next = c_stream_b1;
            end
            c_stream_b1: begin
                if (rx_done_i)          w_next = c_stream_b2;
                else if (w_gap_expired) w_next = c_stream_b0;
            end
            c_stream_b2: begin
                if (rx_done_i)          w_next = c_stream_b0;
                else if (w_gap_expired) w_next = c_stream_b0;
            end
            c_error: w_next = c_error;
            default: w_next = c_send_rst;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic (registered below so all outputs are 0 in reset)
    // ------------------------------------------------------------------------
    always_comb begin
        w_tx_en_nxt     = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        case (r_state)
            c_send_rst: begin
                w_tx_en_nxt   = 1'b1;
                w_tx_data_nxt = c_cmd_reset;
            end
            c_send_en: begin
                w_tx_en_nxt   = 1'b1;
                w_tx_data_nxt = c_cmd_enable;
            end
            default: ;
        endcase
        w_init_done_nxt = (w_next == c_stream_b0) || (w_next == c_stream_b1) ||
                          (w_next == c_stream_b2);
        w_error_nxt     = (w_next == c_error);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_tx_en     <= 1'b0;
            r_tx_data   <= 8'h00;
            r_init_done <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_tx_en     <= w_tx_en_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_init_done <= w_init_done_nxt;
            r_error     <= w_error_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Packet assembly
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_hdr       <= '0;
            r_b1        <= 8'h00;
            r_pkt_valid <= 1'b0;
            r_dx        <= 9'h000;
            r_dy        <= 9'h000;
            r_btn       <= 3'b000;
        end else begin
            r_pkt_valid <= 1'b0;
            if (rx_done_i) begin
                case (r_state)
                    c_stream_b0: begin
                        if (rx_data_i[3]) r_hdr <= {rx_data_i[7:4], rx_data_i[2:0]};
                    end
                    c_stream_b1: r_b1 <= rx_data_i;
                    c_stream_b2: begin
                        r_pkt_valid <= 1'b1;
                        // r_hdr[5]=xovf, [6]=yovf, [3]=xsign, [4]=ysign
                        r_dx  <= r_hdr[5] ? 9'h000 : {r_hdr[3], r_b1};
                        r_dy  <= r_hdr[6] ? 9'h000 : {r_hdr[4], rx_data_i};
                        r_btn <= r_hdr[2:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tx_en_o     = r_tx_en;
    assign tx_data_o   = r_tx_data;
    assign init_done_o = r_init_done;
    assign error_o     = r_error;
    assign pkt_valid_o = r_pkt_valid;
    assign dx_o        = r_dx;
    assign dy_o        = r_dy;
    assign btn_o       = r_btn;

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_mouse_ctrl
// Purpose  : Directed self-checking bench for ps2_mouse_ctrl: bring-up,
//            packet decode, resync, overflow, gap timeout, reset and init
//            failure behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_ctrl;

    localparam int TIMEOUT = 1000;
    localparam int GAP     = 100;
    localparam int RETRIES = 3;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_done_i = 1'b0;
    logic       tx_done_i = 1'b0;
    logic       tx_en_o;
    logic [7:0] tx_data_o;
    logic       init_done_o;
    logic       error_o;
    logic       pkt_valid_o;
    logic [8:0] dx_o;
    logic [8:0] dy_o;
    logic [2:0] btn_o;

    int checks   = 0;
    int failures = 0;
    int tx_cnt   = 0;
    int pkt_cnt  = 0;
    logic [7:0] tx_hist [0:15];

    always #5 clk = ~clk;

    ps2_mouse_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .PKT_GAP_CYCLES(GAP),
        .MAX_RETRIES   (RETRIES)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .rx_data_i  (rx_data_i),
        .rx_done_i  (rx_done_i),
        .tx_done_i  (tx_done_i),
        .tx_en_o    (tx_en_o),
        .tx_data_o  (tx_data_o),
        .init_done_o(init_done_o),
        .error_o    (error_o),
        .pkt_valid_o(pkt_valid_o),
        .dx_o       (dx_o),
        .dy_o       (dy_o),
        .btn_o      (btn_o)
    );

    // Strobe monitors
    always @(negedge clk) begin
        if (tx_en_o === 1'b1) begin
            if (tx_cnt < 16) tx_hist[tx_cnt] = tx_data_o;
            tx_cnt = tx_cnt + 1;
        end
        if (pkt_valid_o === 1'b1) pkt_cnt = pkt_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data_i = b;
        rx_done_i = 1'b1;
        @(negedge clk);
        rx_done_i = 1'b0;
    endtask

    task automatic wait_tx(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_en_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic tx_ack();
        repeat (2) @(negedge clk);
        tx_done_i = 1'b1;
        @(negedge clk);
        tx_done_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i   = 1'b1;
        rx_done_i = 1'b0;
        tx_done_i = 1'b0;
        tx_cnt    = 0;
        repeat (2) @(negedge clk);
        reset_i   = 1'b0;
    endtask

    task automatic bring_up(output bit ok);
        bit o1, o2;
        wait_tx(o1);
        tx_ack();
        send_byte(8'hFA);
        send_byte(8'hAA);
        send_byte(8'h00);
        wait_tx(o2);
        tx_ack();
        send_byte(8'hFA);
        @(negedge clk);
        ok = o1 && o2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx_en_o !== 1'b0)     begin failures++; $display("FAIL reset_tx_en got=%b exp=0", tx_en_o); end
        checks++; if (tx_data_o !== 8'h00)  begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data_o); end
        checks++; if (init_done_o !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", init_done_o); end
        checks++; if (error_o !== 1'b0)     begin failures++; $display("FAIL reset_error got=%b exp=0", error_o); end
        checks++; if (pkt_valid_o !== 1'b0) begin failures++; $display("FAIL reset_pkt_valid got=%b exp=0", pkt_valid_o); end
        checks++; if (dx_o !== 9'h000)      begin failures++; $display("FAIL reset_dx got=%h exp=000", dx_o); end
        checks++; if (dy_o !== 9'h000)      begin failures++; $display("FAIL reset_dy got=%h exp=000", dy_o); end
        checks++; if (btn_o !== 3'b000)     begin failures++; $display("FAIL reset_btn got=%b exp=000", btn_o); end
        tx_cnt  = 0;
        reset_i = 1'b0;
    endtask

    task automatic test_normal_init();
        bit ok;
        bring_up(ok);
        @(negedge clk);
        checks++; if (ok !== 1'b1)          begin failures++; $display("FAIL init_tx_strobe_seen got=%b exp=1", ok); end
        checks++; if (tx_cnt !== 2)         begin failures++; $display("FAIL init_tx_count got=%0d exp=2", tx_cnt); end
        checks++; if (tx_hist[0] !== 8'hFF) begin failures++; $display("FAIL init_first_cmd got=%h exp=FF", tx_hist[0]); end
        checks++; if (tx_hist[1] !== 8'hF4) begin failures++; $display("FAIL init_second_cmd got=%h exp=F4", tx_hist[1]); end
        checks++; if (init_done_o !== 1'b1) begin failures++; $display("FAIL init_done got=%b exp=1", init_done_o); end
        checks++; if (error_o !== 1'b0)     begin failures++; $display("FAIL init_error got=%b exp=0", error_o); end
    endtask

    task automatic test_packet();
        int p0;
        p0 = pkt_cnt;
        // Header 0x09: left button, no sign bits, no overflow
        send_byte(8'h09);
        send_byte(8'h05);
        checks++; if (pkt_valid_o !== 1'b0) begin failures++; $display("FAIL pkt_early_valid got=%b exp=0", pkt_valid_o); end
        send_byte(8'hFE);
        checks++; if (pkt_valid_o !== 1'b1) begin failures++; $display("FAIL pkt1_valid got=%b exp=1", pkt_valid_o); end
        checks++; if (dx_o !== 9'h005)      begin failures++; $display("FAIL pkt1_dx got=%h exp=005", dx_o); end
        checks++; if (dy_o !== 9'h0FE)      begin failures++; $display("FAIL pkt1_dy got=%h exp=0FE", dy_o); end
        checks++; if (btn_o !== 3'b001)     begin failures++; $display("FAIL pkt1_btn got=%b exp=001", btn_o); end
        @(negedge clk);
        checks++; if (pkt_valid_o !== 1'b0) begin failures++; $display("FAIL pkt1_valid_one_cycle got=%b exp=0", pkt_valid_o); end
        checks++; if (dx_o !== 9'h005)      begin failures++; $display("FAIL pkt1_dx_hold got=%h exp=005", dx_o); end
        // Header 0x29: Y sign set -> dy = {1,FE} = -2
        send_byte(8'h29);
        send_byte(8'hFF);
        send_byte(8'hFE);
        checks++; if (pkt_valid_o !== 1'b1) begin failures++; $display("FAIL pkt2_valid got=%b exp=1", pkt_valid_o); end
        checks++; if (dx_o !== 9'h0FF)      begin failures++; $display("FAIL pkt2_dx got=%h exp=0FF", dx_o); end
        checks++; if (dy_o !== 9'h1FE)      begin failures++; $display("FAIL pkt2_dy got=%h exp=1FE", dy_o); end
        repeat (2) @(negedge clk);
        checks++; if (pkt_cnt - p0 !== 2)   begin failures++; $display("FAIL pkt_count got=%0d exp=2", pkt_cnt - p0); end
    endtask

    task automatic test_resync_overflow();
        int p0;
        p0 = pkt_cnt;
        send_byte(8'h00);              // bit3=0: not a header, dropped
        send_byte(8'h58);              // X overflow, X sign, no buttons
        send_byte(8'h10);
        send_byte(8'h20);
        checks++; if (pkt_valid_o !== 1'b1) begin failures++; $display("FAIL resync_valid got=%b exp=1", pkt_valid_o); end
        checks++; if (dx_o !== 9'h000)      begin failures++; $display("FAIL xovf_dx got=%h exp=000", dx_o); end
        checks++; if (dy_o !== 9'h020)      begin failures++; $display("FAIL xovf_dy got=%h exp=020", dy_o); end
        checks++; if (btn_o !== 3'b000)     begin failures++; $display("FAIL xovf_btn got=%b exp=000", btn_o); end
        send_byte(8'hA8);              // Y overflow, Y sign
        send_byte(8'h03);
        send_byte(8'h04);
        checks++; if (dx_o !== 9'h003)      begin failures++; $display("FAIL yovf_dx got=%h exp=003", dx_o); end
        checks++; if (dy_o !== 9'h000)      begin failures++; $display("FAIL yovf_dy got=%h exp=000", dy_o); end
        repeat (2) @(negedge clk);
        checks++; if (pkt_cnt - p0 !== 2)   begin failures++; $display("FAIL resync_count got=%0d exp=2", pkt_cnt - p0); end
    endtask

    task automatic test_gap_timeout();
        int p0;
        p0 = pkt_cnt;
        send_byte(8'h08);
        send_byte(8'h01);
        repeat (GAP + 10) @(negedge clk);
        send_byte(8'h09);
        send_byte(8'h02);
        send_byte(8'h03);
        checks++; if (pkt_valid_o !== 1'b1) begin failures++; $display("FAIL gap_valid got=%b exp=1", pkt_valid_o); end
        checks++; if (dx_o !== 9'h002)      begin failures++; $display("FAIL gap_dx got=%h exp=002", dx_o); end
        checks++; if (dy_o !== 9'h003)      begin failures++; $display("FAIL gap_dy got=%h exp=003", dy_o); end
        checks++; if (btn_o !== 3'b001)     begin failures++; $display("FAIL gap_btn got=%b exp=001", btn_o); end
        repeat (2) @(negedge clk);
        checks++; if (pkt_cnt - p0 !== 1)   begin failures++; $display("FAIL gap_count got=%0d exp=1", pkt_cnt - p0); end
        // A gap shorter than the limit keeps the packet together
        send_byte(8'h08);
        send_byte(8'h01);
        repeat (GAP / 2) @(negedge clk);
        send_byte(8'h02);
        checks++; if (pkt_valid_o !== 1'b1) begin failures++; $display("FAIL short_gap_valid got=%b exp=1", pkt_valid_o); end
        checks++; if (dx_o !== 9'h001)      begin failures++; $display("FAIL short_gap_dx got=%h exp=001", dx_o); end
        checks++; if (dy_o !== 9'h002)      begin failures++; $display("FAIL short_gap_dy got=%h exp=002", dy_o); end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        send_byte(8'h09);
        send_byte(8'h05);
        @(negedge clk);
        reset_i = 1'b1;
        tx_cnt  = 0;
        @(negedge clk);
        checks++; if (init_done_o !== 1'b0) begin failures++; $display("FAIL rst_mid_init_done got=%b exp=0", init_done_o); end
        checks++; if (dx_o !== 9'h000)      begin failures++; $display("FAIL rst_mid_dx got=%h exp=000", dx_o); end
        checks++; if (dy_o !== 9'h000)      begin failures++; $display("FAIL rst_mid_dy got=%h exp=000", dy_o); end
        checks++; if (btn_o !== 3'b000)     begin failures++; $display("FAIL rst_mid_btn got=%b exp=000", btn_o); end
        checks++; if (tx_en_o !== 1'b0)     begin failures++; $display("FAIL rst_mid_tx_en got=%b exp=0", tx_en_o); end
        reset_i = 1'b0;
        wait_tx(ok);
        checks++; if (ok !== 1'b1)          begin failures++; $display("FAIL rst_mid_resend got=%b exp=1", ok); end
        checks++; if (tx_data_o !== 8'hFF)  begin failures++; $display("FAIL rst_mid_cmd got=%h exp=FF", tx_data_o); end
        checks++; if (init_done_o !== 1'b0) begin failures++; $display("FAIL rst_mid_init_after got=%b exp=0", init_done_o); end
    endtask

    // Entered with the FF strobe of a fresh bring-up already seen.
    task automatic test_init_error();
        int exp_tx;
        exp_tx = 1;
        tx_ack();
        send_byte(8'hFC);
`ifdef MOUSE_RETRY_EN
        for (int r = 0; r < RETRIES; r++) begin
            bit ok;
            wait_tx(ok);
            checks++; if (ok !== 1'b1) begin failures++; $display("FAIL retry_resend_%0d got=%b exp=1", r, ok); end
            tx_ack();
            send_byte(8'hFC);
        end
        exp_tx = 1 + RETRIES;
`endif
        checks++; if (error_o !== 1'b1)     begin failures++; $display("FAIL err_flag got=%b exp=1", error_o); end
        checks++; if (init_done_o !== 1'b0) begin failures++; $display("FAIL err_init_done got=%b exp=0", init_done_o); end
        repeat (50) @(negedge clk);
        checks++; if (tx_cnt !== exp_tx)    begin failures++; $display("FAIL err_tx_count got=%0d exp=%0d", tx_cnt, exp_tx); end
        checks++; if (tx_hist[exp_tx-1] !== 8'hFF) begin failures++; $display("FAIL err_last_cmd got=%h exp=FF", tx_hist[exp_tx-1]); end
        checks++; if (error_o !== 1'b1)     begin failures++; $display("FAIL err_latched got=%b exp=1", error_o); end
    endtask

    task automatic test_init_timeout();
        bit ok;
        int n;
        do_reset();
        wait_tx(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL to_first_cmd got=%b exp=1", ok); end
        tx_ack();
        n = 0;
        while (error_o !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (error_o !== 1'b1) begin failures++; $display("FAIL to_error got=%b exp=1 after %0d cycles", error_o, n); end
`ifndef MOUSE_RETRY_EN
        checks++; if (n < TIMEOUT - 10 || n > TIMEOUT + 10) begin failures++; $display("FAIL to_latency got=%0d exp~%0d", n, TIMEOUT); end
        checks++; if (tx_cnt !== 1) begin failures++; $display("FAIL to_tx_count got=%0d exp=1", tx_cnt); end
`endif
    endtask

    initial begin
        bit ok;
        test_reset();
        test_normal_init();
        test_packet();
        test_resync_overflow();
        test_gap_timeout();
        test_reset_mid_packet();
        test_init_error();
        test_init_timeout();
        // Recovery: a fresh reset after ERROR brings the mouse up again
        do_reset();
        bring_up(ok);
        @(negedge clk);
        checks++; if (init_done_o !== 1'b1 || error_o !== 1'b0) begin
            failures++; $display("FAIL recover got init_done=%b error=%b exp init_done=1 error=0", init_done_o, error_o);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
